// File: rtl/lsu_pkg.sv
// Shared LSU types and constants.
//   byte_en_t    : per-byte write enables for one 32-bit word
//   word_t       : 32-bit data word
//   dmem_state_e : data-memory controller states (clear sweep / idle)
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [3:0]  byte_en_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        DMEM_CLEAR,
        DMEM_IDLE
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: DEPTH x 8-bit synchronous RAM.
// Ports:
//   clk, rst_n : clock, async active-low reset (read register only)
//   we         : write wdata to mem[addr] on the rising edge
//   re         : capture a read into rdata on the rising edge
//   rd_zero    : when reading, load 0 instead of mem[addr]
//   addr       : shared read/write word index
//   wdata      : write byte
//   rdata      : registered read byte, holds between reads
module dmem_lane #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic          rd_zero,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Array has no reset; contents are cleared by the controller's sweep.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= rd_zero ? 8'h00 : mem[addr];
    end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous-read byte-lane data memory for the LSU.
// One load or store per cycle behind ready/valid; load data returns one
// cycle after acceptance. After reset (INIT_CLEAR=1) a clear engine writes
// zero to every word before o_ready rises.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag and suppress accesses
// outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS); otherwise o_err is 0 and
// addresses wrap modulo the array size.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req, i_we    : request, 1=store 0=load
//   i_addr         : byte address (bits [1:0] ignored)
//   i_wr_data      : store data, i_wren : byte-lane write enables
//   o_ready        : request can be accepted this cycle
//   o_rd_data      : registered load data (holds when o_rd_valid=0)
//   o_rd_valid     : one-cycle load-data pulse
//   o_err          : one-cycle out-of-range pulse
module dmem_sync
    import lsu_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h2000,
    parameter int                DEPTH_WORDS = 2048,
    parameter bit                INIT_CLEAR  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  word_t             i_wr_data,
    input  byte_en_t          i_wren,
    output logic              o_ready,
    output word_t             o_rd_data,
    output logic              o_rd_valid,
    output logic              o_err
);

    localparam int               IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH_WORDS - 1);

    dmem_state_e      state, state_nxt;
    logic [IDX_W-1:0] clr_cnt;
    logic             accept;
    logic             oor;
    logic [IDX_W-1:0] req_idx;

    byte_en_t         lane_we;
    logic             lane_re;
    logic [IDX_W-1:0] lane_addr;
    word_t            lane_wdata;

    assign o_ready = (state == DMEM_IDLE);
    assign accept  = i_req && o_ready;

    // Offset from base is modulo 2^ADDR_W, then truncated to the word index.
    assign req_idx = IDX_W'((i_addr - BASE_ADDR) >> 2);

`ifdef DMEM_RANGE_CHECK_EN
    // One extra bit so BASE_ADDR + array bytes cannot overflow.
    localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(WORD_BYTES * DEPTH_WORDS);
    logic [ADDR_W:0] addr_x;
    assign addr_x = {1'b0, i_addr};
    assign oor    = (addr_x < LO) || (addr_x >= HI);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_err <= 1'b0;
        else          o_err <= accept && oor;
    end
`else
    assign oor   = 1'b0;
    assign o_err = 1'b0;
`endif

    // Controller state and clear counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= INIT_CLEAR ? DMEM_CLEAR : DMEM_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DMEM_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        if (state == DMEM_CLEAR && clr_cnt == LAST) state_nxt = DMEM_IDLE;
    end

    // Single write/read port: clear sweep owns it in CLEAR, requests in IDLE.
    always_comb begin
        lane_we    = '0;
        lane_re    = 1'b0;
        lane_addr  = req_idx;
        lane_wdata = i_wr_data;
        if (state == DMEM_CLEAR) begin
            lane_we    = 4'hF;
            lane_addr  = clr_cnt;
            lane_wdata = '0;
        end else begin
            if (accept && i_we && !oor) lane_we = i_wren;
            lane_re = accept && !i_we;
        end
    end

    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
        dmem_lane #(
            .DEPTH (DEPTH_WORDS),
            .AW    (IDX_W)
        ) u_lane (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .we      (lane_we[k]),
            .re      (lane_re),
            .rd_zero (oor),
            .addr    (lane_addr),
            .wdata   (lane_wdata[8*k +: 8]),
            .rdata   (o_rd_data[8*k +: 8])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_rd_valid <= 1'b0;
        else          o_rd_valid <= accept && !i_we;
    end

endmodule

// File: tb/tb_dmem_sync.sv
// Directed self-checking bench for dmem_sync (default parameters).
// Expectations for the out-of-range rows follow DMEM_RANGE_CHECK_EN.
module tb_dmem_sync;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [15:0] i_addr;
    logic [31:0] i_wr_data;
    logic [3:0]  i_wren;
    logic        o_ready;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_err;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    always #5 i_clk = ~i_clk;

    dmem_sync dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wren     (i_wren),
        .o_ready    (o_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_err      (o_err)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wren;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Count rising edges until o_ready is seen high (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 5000) begin
            @(posedge i_clk); #1;
            n++;
            if (o_ready) break;
        end
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = a; i_wr_data = d; i_wren = be;
        @(posedge i_clk); #1;
        i_req = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, output logic v, output logic [31:0] d);
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = a;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        v = o_rd_valid;
        d = o_rd_data;
    endtask

    initial begin
        int          n;
        logic        v;
        logic [31:0] d;
        int          pulses;

        tbl[0]  = '{1'b1, 16'h2004, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 16'h2004, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 16'h2004, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEAA, 1'b0};
        tbl[3]  = '{1'b1, 16'h2010, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 16'h2010, 32'h0,        4'h0, 1'b1, 1'b1, 32'h12345678, 1'b0};
        tbl[5]  = '{1'b1, 16'h3FFC, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 16'h2000, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 16'h3FFC, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0};
        tbl[8]  = '{1'b0, 16'h2000, 32'h0,        4'h0, 1'b1, 1'b1, 32'h11223344, 1'b0};
        // no-op store; read data must hold the previous load
        tbl[9]  = '{1'b1, 16'h2008, 32'hA5A5A5A5, 4'h0, 1'b0, 1'b1, 32'h11223344, 1'b0};
        tbl[10] = '{1'b0, 16'h2008, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000, 1'b0};
        tbl[11] = '{1'b1, 16'h2008, 32'h55667788, 4'hA, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 16'h200B, 32'h0,        4'h0, 1'b1, 1'b1, 32'h55007700, 1'b0};
        tbl[13] = '{1'b0, 16'h2004, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'hDEADBEAA, 1'b0};
        tbl[14] = '{1'b1, 16'h4000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 32'h0, RC};
        tbl[15] = '{1'b0, 16'h1FFC, 32'h0,        4'h0, 1'b1, 1'b1, RC ? 32'h0 : 32'hCAFEF00D, RC};
        tbl[16] = '{1'b0, 16'h2000, 32'h0,        4'h0, 1'b1, 1'b1, RC ? 32'h11223344 : 32'hFFFFFFFF, 1'b0};
        tbl[17] = '{1'b0, 16'h3FFC, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0};

        // Reset with a store held on the bus through the whole sweep.
        i_rst_n = 1'b0;
        i_req = 1'b1; i_we = 1'b1; i_addr = 16'h2000;
        i_wr_data = 32'h77777777; i_wren = 4'hF;
        #2;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_data", o_rd_data, 32'h0);
        chk("rst_err", 32'(o_err), 32'd0);
        #21 i_rst_n = 1'b1;
        wait_ready(n);
        i_req = 1'b0;
        chk("sweep_len", 32'(n), 32'd2048);
        load(16'h2000, v, d);
        chk("drop_during_clear", d, 32'h0);

        // Preload, then reset with a load in flight and again mid-sweep.
        store(16'h2000, 32'hABCD0123, 4'hF);
        load(16'h2000, v, d);
        chk("preload_rd", d, 32'hABCD0123);
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 16'h2000;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("inflight_valid", 32'(o_rd_valid), 32'd0);
        chk("inflight_data", o_rd_data, 32'h0);
        #10 i_rst_n = 1'b1;
        repeat (1000) @(posedge i_clk);
        #1;
        chk("midsweep_busy", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #3 i_rst_n = 1'b1;
        wait_ready(n);
        chk("resweep_len", 32'(n), 32'd2048);
        load(16'h2000, v, d);
        chk("cleared_valid", 32'(v), 32'd1);
        chk("cleared_word", d, 32'h0);

        // Back-to-back table: one row per cycle, outputs checked after the edge.
        for (int i = 0; i < 18; i++) begin
            @(negedge i_clk);
            i_req = 1'b1; i_we = tbl[i].we; i_addr = tbl[i].addr;
            i_wr_data = tbl[i].wdata; i_wren = tbl[i].wren;
            @(posedge i_clk); #1;
            chk($sformatf("row%0d_valid", i), 32'(o_rd_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("row%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
            if (tbl[i].chk_data)
                chk($sformatf("row%0d_data", i), o_rd_data, tbl[i].exp_data);
        end
        @(negedge i_clk);
        i_req = 1'b0;

        // Stream of 8 loads gives 8 consecutive valid pulses.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            i_req = 1'b1; i_we = 1'b0; i_addr = 16'(16'h2000 + 4 * i);
            @(posedge i_clk); #1;
            if (o_rd_valid) pulses++;
        end
        @(negedge i_clk);
        i_req = 1'b0;
        chk("stream_pulses", 32'(pulses), 32'd8);
        @(posedge i_clk); #1;
        chk("stream_end_valid", 32'(o_rd_valid), 32'd0);
        chk("stream_last_data", o_rd_data, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
